game_sequencer: RTL

//  Central controller of the memory game. Builds a random digit sequence, plays
//  it to the 7-seg display one digit at a time, then checks the player's PS/2

---
 rtl/game_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: builds, plays back and checks the memory-game digit sequence.
// Define ENTRY_TIMEOUT_EN to lose after TIMEOUT_TICKS idle blink ticks in ENTER.
module game_sequencer #(
    parameter int MAX_LEN    = 16,
    parameter int SHOW_TICKS = 2,
    parameter int GAP_TICKS  = 1
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 8
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_blink_tick,
    input  logic [15:0] i_seed,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_digit,
    output logic        o_game_on,
    output logic        o_display_phase,
    output logic        o_enter_phase,
    output logic        o_show_valid,
    output logic [3:0]  o_show_digit,
    output logic [4:0]  o_level,
    output logic        o_win,
    output logic        o_lose
);
    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, ENTER, WIN, LOSE} state_t;
    localparam logic [4:0] L_MAX  = 5'(MAX_LEN);
    localparam logic [7:0] L_SHOW = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] L_GAP  = 8'(GAP_TICKS - 1);
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [7:0] L_TOUT = 8'(TIMEOUT_TICKS - 1);
`endif
    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_mem [16];
    logic [3:0]  r_idx;
    logic [7:0]  r_ticks;
    logic [15:0] w_lfsr_nx;
    logic [3:0]  w_digit;
    logic [3:0]  w_last;
    logic [3:0]  w_idx_p1;
    logic        w_key_ok;

    always_comb begin
        w_lfsr_nx = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_digit   = (w_lfsr_nx[3:0] > 4'd9) ? w_lfsr_nx[3:0] - 4'd6 : w_lfsr_nx[3:0];
        w_last    = 4'(o_level - 5'd1);
        w_idx_p1  = r_idx + 4'd1;
        w_key_ok  = i_key_valid && (i_key_digit <= 4'd9);
    end

    // Sequence storage is deliberately not reset.
    always_ff @(posedge clk)
        if (r_state == GEN)
            r_mem[w_last] <= w_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_lfsr          <= 16'hACE1;
            r_idx           <= '0;
            r_ticks         <= '0;
            o_game_on       <= 1'b0;
            o_display_phase <= 1'b0;
            o_enter_phase   <= 1'b0;
            o_show_valid    <= 1'b0;
            o_show_digit    <= '0;
            o_level         <= 5'd1;
            o_win           <= 1'b0;
            o_lose          <= 1'b0;
        end else begin
            r_ticks <= r_ticks + {7'd0, i_blink_tick};
            case (r_state)
                IDLE, WIN, LOSE: begin
                    if (i_start) begin
                        r_state         <= GEN;
                        r_lfsr          <= (i_seed == 16'd0) ? 16'hACE1 : i_seed;
                        r_idx           <= '0;
                        r_ticks         <= '0;
                        o_level         <= 5'd1;
                        o_win           <= 1'b0;
                        o_lose          <= 1'b0;
                        o_game_on       <= 1'b1;
                        o_display_phase <= 1'b1;
                    end
                end
                GEN: begin
                    r_state      <= SHOW_ON;
                    r_lfsr       <= w_lfsr_nx;
                    r_idx        <= '0;
                    r_ticks      <= '0;
                    o_show_valid <= 1'b1;
                    // At level 1 the digit being written is the one shown first.
                    o_show_digit <= (w_last == 4'd0) ? w_digit : r_mem[0];
                end
                SHOW_ON: begin
                    if (i_blink_tick && r_ticks == L_SHOW) begin
                        r_state      <= SHOW_OFF;
                        r_ticks      <= '0;
                        o_show_valid <= 1'b0;
                        o_show_digit <= '0;
                    end
                end
                SHOW_OFF: begin
                    if (i_blink_tick && r_ticks == L_GAP) begin
                        r_ticks <= '0;
                        if (r_idx == w_last) begin
                            r_state         <= ENTER;
                            r_idx           <= '0;
                            o_display_phase <= 1'b0;
                            o_enter_phase   <= 1'b1;
                        end else begin
                            r_state      <= SHOW_ON;
                            r_idx        <= w_idx_p1;
                            o_show_valid <= 1'b1;
                            o_show_digit <= r_mem[w_idx_p1];
                        end
                    end
                end
                ENTER: begin
                    if (w_key_ok) begin
                        r_ticks <= '0;
                        if (i_key_digit != r_mem[r_idx]) begin
                            r_state       <= LOSE;
                            o_lose        <= 1'b1;
                            o_enter_phase <= 1'b0;
                        end else if (r_idx != w_last) begin
                            r_idx <= w_idx_p1;
                        end else if (o_level == L_MAX) begin
                            r_state       <= WIN;
                            o_win         <= 1'b1;
                            o_enter_phase <= 1'b0;
                        end else begin
                            r_state         <= GEN;
                            o_level         <= o_level + 5'd1;
                            o_enter_phase   <= 1'b0;
                            o_display_phase <= 1'b1;
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (i_blink_tick && r_ticks == L_TOUT) begin
                        r_state       <= LOSE;
                        o_lose        <= 1'b1;
                        o_enter_phase <= 1'b0;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
